// File: rtl/dmd_frame_capture.sv
// dmd_frame_capture: receiving end of the dot-matrix scan interface.
// Synchronizes the scanner signals into CLK, collects scanned rows into a
// back buffer and, once every row of a frame has been seen, swaps it into
// a display buffer that is read through a registered row port.
//
// Ports:
//   CLK, RESET         system clock, synchronous active-high reset
//   DMD_CLK            row strobe from the scanner (slow relative to CLK)
//   DMD_CLR            scanner clear, aborts the frame being collected
//   dmd_seg            row index, valid at the DMD_CLK rising edge
//   dmd_column         row pixel data, valid at the DMD_CLK rising edge
//   rd_row / rd_data   display-buffer row read, data registered
//   frame_done         one-CLK pulse when a frame is swapped in
//   frame_valid        high once any frame has been swapped since reset
//   frame_error        one-CLK pulse when a frame is rejected as incomplete
//   frame_count        number of swapped frames, wraps at 256
//
// ROWS is expected to be a power of two between 2 and 16.
module dmd_frame_capture #(
    parameter int unsigned ROWS           = 16,
    parameter int unsigned COLS           = 16,
    parameter bit          COL_ACTIVE_LOW = 1'b0
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            DMD_CLK,
    input  logic            DMD_CLR,
    input  logic [3:0]      dmd_seg,
    input  logic [COLS-1:0] dmd_column,
    input  logic [3:0]      rd_row,
    output logic [COLS-1:0] rd_data,
    output logic            frame_done,
    output logic            frame_valid,
    output logic            frame_error,
    output logic [7:0]      frame_count
);

    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RW-1:0]   LAST_ROW  = RW'(ROWS - 1);
    localparam logic [ROWS-1:0] MASK_FULL = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_SWAP
    } state_e;

    // Two-stage synchronizer; strobe, clear, row and data travel together
    logic            s1_clk_q, s2_clk_q, s3_clk_q;
    logic            s1_clr_q, s2_clr_q;
    logic [RW-1:0]   s1_row_q, s2_row_q;
    logic [COLS-1:0] s1_col_q, s2_col_q;

    logic [COLS-1:0] back_q    [ROWS];
    logic [COLS-1:0] display_q [ROWS];
    logic [ROWS-1:0] mask_q, mask_d;
    state_e          state_q, state_d;

    logic [COLS-1:0] rd_data_q;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            valid_q;
    logic [7:0]      count_q;

    logic            strobe;
    logic            wr_en;
    logic            swap_en;
    logic [ROWS-1:0] row_bit;
    logic [COLS-1:0] col_data;

    assign strobe   = s2_clk_q & ~s3_clk_q;
    assign row_bit  = ROWS'(1) << s2_row_q;
    assign col_data = COL_ACTIVE_LOW ? ~s2_col_q : s2_col_q;

    // Synchronizer and edge-detect registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_clk_q <= 1'b0;
            s2_clk_q <= 1'b0;
            s3_clk_q <= 1'b0;
            s1_clr_q <= 1'b0;
            s2_clr_q <= 1'b0;
            s1_row_q <= '0;
            s2_row_q <= '0;
            s1_col_q <= '0;
            s2_col_q <= '0;
        end else begin
            s1_clk_q <= DMD_CLK;
            s2_clk_q <= s1_clk_q;
            s3_clk_q <= s2_clk_q;
            s1_clr_q <= DMD_CLR;
            s2_clr_q <= s1_clr_q;
            s1_row_q <= dmd_seg[RW-1:0];
            s2_row_q <= s1_row_q;
            s1_col_q <= dmd_column;
            s2_col_q <= s1_col_q;
        end
    end

    // Frame collection: next state, mask and pulse generation
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        wr_en   = 1'b0;
        swap_en = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_FILL: begin
                if (s2_clr_q) begin
                    // Clear wins over a coincident strobe; back buffer kept
                    mask_d  = '0;
                    state_d = ST_IDLE;
                end else if (strobe) begin
                    wr_en = 1'b1;
                    if (s2_row_q == LAST_ROW) begin
                        if ((state_q == ST_FILL) && ((mask_q | row_bit) == MASK_FULL)) begin
                            state_d = ST_SWAP;
                        end else begin
                            // Last row arrived with rows missing: reject frame
                            err_d   = 1'b1;
                            mask_d  = '0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        mask_d  = mask_q | row_bit;
                        state_d = ST_FILL;
                    end
                end
            end
            ST_SWAP: begin
                // A completed frame is committed even if a clear arrives now
                swap_en = 1'b1;
                done_d  = 1'b1;
                mask_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                mask_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, buffers and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            rd_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            count_q   <= 8'd0;
            for (int i = 0; i < int'(ROWS); i++) begin
                back_q[i]    <= '0;
                display_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (wr_en) begin
                back_q[s2_row_q] <= col_data;
            end
            if (swap_en) begin
                for (int i = 0; i < int'(ROWS); i++) begin
                    display_q[i] <= back_q[i];
                end
                valid_q <= 1'b1;
                count_q <= count_q + 8'd1;
            end
            // Reads the pre-swap contents during the swap cycle
            rd_data_q <= display_q[rd_row[RW-1:0]];
        end
    end

    assign rd_data     = rd_data_q;
    assign frame_done  = done_q;
    assign frame_valid = valid_q;
    assign frame_error = err_q;
    assign frame_count = count_q;

endmodule
